// File: rtl/mult_booth_sched_pkg.sv
// Shared widths and FSM state type for the Booth multiplier scheduler.
package mult_booth_sched_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/mult_booth_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant_onehot,
  output logic [ID_W-1:0] grant_idx,
  output logic            any_req
);

  int unsigned idx;
  logic        found;

  // Scan upward from ptr and keep the first requester found.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[ID_W'(idx)]) begin
        found        = 1'b1;
        grant_idx    = ID_W'(idx);
        grant_onehot = N'(1) << idx;
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/mult_booth_sched.sv
// Round-robin scheduler sharing one external sequential Booth multiplier.
module mult_booth_sched
  import mult_booth_sched_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [OP_W*N-1:0]   req_a,
  input  logic [OP_W*N-1:0]   req_b,
  output logic [N-1:0]        req_ready,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [PROD_W-1:0]   rsp_product,
  input  logic                rsp_ready,
  output logic                mult_start,
  output logic [OP_W-1:0]     mult_a,
  output logic [OP_W-1:0]     mult_b,
  input  logic [PROD_W-1:0]   mult_product,
  input  logic                mult_ready,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                first_wait_q, first_wait_d;

  logic [N-1:0]        gnt_oh;
  logic [ID_W-1:0]     gnt_idx;
  logic                any_req;

  rr_arbiter #(
    .N    (N),
    .ID_W (ID_W)
  ) u_arb (
    .req          (req_valid),
    .ptr          (ptr_q),
    .grant_onehot (gnt_oh),
    .grant_idx    (gnt_idx),
    .any_req      (any_req)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      prod_q       <= '0;
      first_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      prod_q       <= prod_d;
      first_wait_q <= first_wait_d;
    end
  end

  // Next-state logic, grant strobe and start pulse.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    prod_d     = prod_q;
    req_ready  = '0;
    mult_start = 1'b0;
    // The multiplier's done flag is stale in the cycle right after start.
    first_wait_d = (state_q == ISSUE);
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = gnt_oh;
          a_d       = req_a[gnt_idx*OP_W +: OP_W];
          b_d       = req_b[gnt_idx*OP_W +: OP_W];
          id_d      = gnt_idx;
          ptr_d     = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        mult_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (!first_wait_q && mult_ready) begin
          prod_d  = mult_product;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_product = prod_q;
  assign mult_a      = a_q;
  assign mult_b      = b_q;
  assign busy        = (state_q != IDLE);

endmodule
